// File: rtl/waveform_pkg.sv
// Shared types for the waveform scheduler: FSM states, candidate config and
// the legality rule applied to every accepted configuration.
package waveform_pkg;

  localparam int CFG_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_MAX_W-1:0] period;
    logic [CFG_MAX_W-1:0] rise;
    logic [CFG_MAX_W-1:0] fall;
  } wave_cfg_t;

  // Callers zero-extend their CNT_W fields, so this equals an unsigned CNT_W compare.
  function automatic logic wave_cfg_valid(input wave_cfg_t c);
    return (c.period >= CFG_MAX_W'(2)) && (c.rise < c.fall) && (c.fall < c.period);
  endfunction

endpackage

// File: rtl/waveform_sched_if.sv
// Config handshake, run control and waveform/tick outputs of the scheduler.
interface waveform_sched_if #(
  parameter int CNT_W  = 8,
  parameter int N_OUT  = 4,
  parameter int PCNT_W = 16
) ();
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_rise;
  logic [CNT_W-1:0]  cfg_fall;
  logic [N_OUT-1:0]  cfg_mask;
  logic              start;
  logic              stop;
  logic              wave_out;
  logic [N_OUT-1:0]  tick;
  logic              busy;
  logic              cfg_ok;
  logic              cfg_err;
  logic [PCNT_W-1:0] periods;

  modport master (
    output cfg_valid, cfg_period, cfg_rise, cfg_fall, cfg_mask, start, stop,
    input  cfg_ready, wave_out, tick, busy, cfg_ok, cfg_err, periods
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_rise, cfg_fall, cfg_mask, start, stop,
    output cfg_ready, wave_out, tick, busy, cfg_ok, cfg_err, periods
  );
endinterface

// File: rtl/waveform_phase_cnt.sv
// Phase counter modulo period with wrap strobe and saturating period count.
module waveform_phase_cnt #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  phase,
  output logic              wrap,
  output logic [PCNT_W-1:0] periods
);
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [PCNT_W-1:0] periods_q, periods_d;

  assign wrap = enable && (phase_q == period - CNT_W'(1));

  // Phase parks at zero whenever the counter is not advancing; the count holds.
  always_comb begin
    phase_d   = '0;
    periods_d = periods_q;
    if (clear) begin
      periods_d = '0;
    end else if (enable) begin
      phase_d = wrap ? '0 : phase_q + CNT_W'(1);
      if (wrap && (periods_q != '1)) begin
        periods_d = periods_q + PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      periods_q <= '0;
    end else begin
      phase_q   <= phase_d;
      periods_q <= periods_d;
    end
  end

  assign phase   = phase_q;
  assign periods = periods_q;
endmodule

// File: rtl/waveform_sched.sv
// Waveform scheduler: validates (period, rise, fall), then emits a registered
// periodic waveform and masked per-consumer ticks at the rise phase.
module waveform_sched
  import waveform_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int N_OUT  = 4,
  parameter int PCNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  waveform_sched_if.slave bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  period_q, period_d, rise_q, rise_d, fall_q, fall_d;
  logic [N_OUT-1:0]  mask_q, mask_d, tick_q, tick_d, tick_hit;
  logic              wave_q, wave_d, cfg_ok_q, cfg_ok_d, cfg_err_q, cfg_err_d;
  logic              accept, cand_ok, go, run_en;
  logic              unused_wrap;
  logic [CNT_W-1:0]  phase;
  logic [PCNT_W-1:0] periods;
  wave_cfg_t         cand;

  assign bus.cfg_ready = (state_q != RUN);
  assign accept        = bus.cfg_valid && (state_q != RUN);

  always_comb begin
    cand.period = CFG_MAX_W'(bus.cfg_period);
    cand.rise   = CFG_MAX_W'(bus.cfg_rise);
    cand.fall   = CFG_MAX_W'(bus.cfg_fall);
  end

  assign cand_ok = wave_cfg_valid(cand);
  // A config accept in the same cycle takes precedence over start.
  assign go      = (state_q == IDLE) && !accept && bus.start && cfg_ok_q && !bus.stop;
  assign run_en  = (state_q == RUN) && !bus.stop;

  waveform_phase_cnt #(
    .CNT_W (CNT_W),
    .PCNT_W(PCNT_W)
  ) u_phase_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (run_en),
    .clear  (go),
    .period (period_q),
    .phase  (phase),
    .wrap   (unused_wrap),
    .periods(periods)
  );

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_tick
    assign tick_hit[gi] = mask_q[gi] && (phase == rise_q);
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    mask_d    = mask_q;
    cfg_ok_d  = cfg_ok_q;
    cfg_err_d = cfg_err_q;
    wave_d    = 1'b0;
    tick_d    = '0;
    case (state_q)
      IDLE, ERR: begin
        if (accept) begin
          period_d  = bus.cfg_period;
          rise_d    = bus.cfg_rise;
          fall_d    = bus.cfg_fall;
          mask_d    = bus.cfg_mask;
          cfg_ok_d  = cand_ok;
          cfg_err_d = !cand_ok;
          state_d   = cand_ok ? IDLE : ERR;
        end else if (go) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          wave_d = (phase >= rise_q) && (phase < fall_q);
          tick_d = tick_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      period_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      mask_q    <= '0;
      cfg_ok_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      wave_q    <= 1'b0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mask_q    <= mask_d;
      cfg_ok_q  <= cfg_ok_d;
      cfg_err_q <= cfg_err_d;
      wave_q    <= wave_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.wave_out = wave_q;
  assign bus.tick     = tick_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.cfg_ok   = cfg_ok_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.periods  = periods;
endmodule

// File: tb/tb_waveform_sched.sv
// Directed bench for waveform_sched with a run-count based reference model
// compared every cycle, plus hand-computed pattern and counter checks.
module tb_waveform_sched;
  localparam int CNT_W  = 8;
  localparam int N_OUT  = 4;
  localparam int PCNT_W = 4;
  localparam int PMAX   = (1 << PCNT_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_ERR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  waveform_sched_if #(.CNT_W(CNT_W), .N_OUT(N_OUT), .PCNT_W(PCNT_W)) bus ();

  waveform_sched #(.CNT_W(CNT_W), .N_OUT(N_OUT), .PCNT_W(PCNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: outputs follow from how many RUN edges have elapsed.
  int         m_state, m_per, m_rise, m_fall, m_n, m_periods;
  logic [3:0] m_mask, m_tick;
  logic       m_ok, m_err, m_wave;

  function automatic logic legal(int p, int r, int f);
    return (p >= 2) && (r < f) && (f < p);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE; m_per <= 0; m_rise <= 0; m_fall <= 0; m_mask <= '0;
      m_n <= 0; m_periods <= 0; m_ok <= 1'b0; m_err <= 1'b0;
      m_wave <= 1'b0; m_tick <= '0;
    end else if (m_state == M_RUN) begin
      if (bus.stop) begin
        m_state <= M_IDLE; m_wave <= 1'b0; m_tick <= '0;
      end else begin
        m_wave    <= ((m_n % m_per) >= m_rise) && ((m_n % m_per) < m_fall);
        m_tick    <= ((m_n % m_per) == m_rise) ? m_mask : 4'b0;
        m_n       <= m_n + 1;
        m_periods <= ((m_n + 1) / m_per > PMAX) ? PMAX : (m_n + 1) / m_per;
      end
    end else if (bus.cfg_valid) begin
      m_per  <= int'(bus.cfg_period);
      m_rise <= int'(bus.cfg_rise);
      m_fall <= int'(bus.cfg_fall);
      m_mask <= bus.cfg_mask;
      if (legal(int'(bus.cfg_period), int'(bus.cfg_rise), int'(bus.cfg_fall))) begin
        m_ok <= 1'b1; m_err <= 1'b0; m_state <= M_IDLE;
      end else begin
        m_ok <= 1'b0; m_err <= 1'b1; m_state <= M_ERR;
      end
    end else if (m_state == M_IDLE && bus.start && m_ok && !bus.stop) begin
      m_state <= M_RUN; m_n <= 0; m_periods <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      vectors++;
      if ({bus.cfg_ready, bus.wave_out, bus.tick, bus.busy, bus.cfg_ok, bus.cfg_err, bus.periods} !==
          {m_state != M_RUN, m_wave, m_tick, m_state == M_RUN, m_ok, m_err, 4'(m_periods)}) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got rdy/wave/tick/busy/ok/err/per=%b/%b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%b/%0d",
                 $time, bus.cfg_ready, bus.wave_out, bus.tick, bus.busy, bus.cfg_ok, bus.cfg_err, bus.periods,
                 m_state != M_RUN, m_wave, m_tick, m_state == M_RUN, m_ok, m_err, m_periods);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [63:0] wave_h;
  logic [63:0] tick_h [N_OUT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cfg(input int p, input int r, input int f, input logic [3:0] m);
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 8'(p);
    bus.cfg_rise   = 8'(r);
    bus.cfg_fall   = 8'(f);
    bus.cfg_mask   = m;
    step(1);
    bus.cfg_valid = 1'b0;
    $display("cfg period=%0d rise=%0d fall=%0d mask=%b -> ok=%b err=%b", p, r, f, m, bus.cfg_ok, bus.cfg_err);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    $display("start -> busy=%b", bus.busy);
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    $display("stop -> busy=%b periods=%0d", bus.busy, bus.periods);
  endtask

  task automatic run_cap(input int n);
    wave_h = '0;
    for (int j = 0; j < N_OUT; j++) tick_h[j] = '0;
    for (int k = 0; k < n; k++) begin
      step(1);
      wave_h[k] = bus.wave_out;
      for (int j = 0; j < N_OUT; j++) tick_h[j][k] = bus.tick[j];
    end
    $display("run %0d cycles wave=%b", n, wave_h[15:0]);
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_rise = '0; bus.cfg_fall = '0;
    bus.cfg_mask = '0; bus.start = 1'b0; bus.stop = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("reset_ready", 32'(bus.cfg_ready), 1);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_cfg_ok", 32'(bus.cfg_ok), 0);
    chk("reset_periods", 32'(bus.periods), 0);

    // Basic run: period 5, rise 1, fall 3, consumers 0 and 2.
    send_cfg(5, 1, 3, 4'b0101);
    chk("t1_cfg_ok", 32'(bus.cfg_ok), 1);
    pulse_start();
    chk("t1_ready_run", 32'(bus.cfg_ready), 0);
    chk("t1_busy", 32'(bus.busy), 1);
    run_cap(10);
    chk("t1_wave_pattern", 32'(wave_h[9:0]), 32'd198);
    chk("t1_tick0", 32'(tick_h[0][9:0]), 32'd66);
    chk("t1_tick2", 32'(tick_h[2][9:0]), 32'd66);
    chk("t1_tick1_3", 32'(tick_h[1][9:0] | tick_h[3][9:0]), 0);
    chk("t1_periods", 32'(bus.periods), 2);
    do_stop();

    // Rejected configs.
    send_cfg(1, 0, 0, 4'b1111);
    chk("t2_err_p1", 32'(bus.cfg_err), 1);
    chk("t2_ready_err", 32'(bus.cfg_ready), 1);
    pulse_start();
    step(1);
    chk("t2_start_ignored", 32'(bus.busy), 0);
    chk("t2_wave_low", 32'(bus.wave_out), 0);
    send_cfg(8, 3, 3, 4'b1111);
    chk("t2_err_rise_eq_fall", 32'(bus.cfg_err), 1);
    send_cfg(8, 2, 8, 4'b1111);
    chk("t2_err_fall_eq_period", 32'(bus.cfg_err), 1);
    send_cfg(4, 0, 2, 4'b1111);
    chk("t2_valid_err", 32'(bus.cfg_err), 0);
    chk("t2_valid_ok", 32'(bus.cfg_ok), 1);

    // Start and stop together while running: stop wins.
    pulse_start();
    run_cap(10);
    chk("t3_wave_pattern", 32'(wave_h[9:0]), 32'd819);
    chk("t3_tick3", 32'(tick_h[3][9:0]), 32'd273);
    bus.start = 1'b1; bus.stop = 1'b1;
    step(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    $display("start+stop -> busy=%b periods=%0d", bus.busy, bus.periods);
    chk("t3_busy", 32'(bus.busy), 0);
    chk("t3_wave", 32'(bus.wave_out), 0);
    chk("t3_tick", 32'(bus.tick), 0);
    chk("t3_periods", 32'(bus.periods), 2);
    step(3);
    chk("t3_periods_hold", 32'(bus.periods), 2);

    // Config offered during RUN waits for IDLE.
    pulse_start();
    step(2);
    bus.cfg_valid = 1'b1; bus.cfg_period = 8'd6; bus.cfg_rise = 8'd1;
    bus.cfg_fall = 8'd4; bus.cfg_mask = 4'b0010;
    step(1);
    chk("t4_ready_run", 32'(bus.cfg_ready), 0);
    step(2);
    chk("t4_still_busy", 32'(bus.busy), 1);
    do_stop();
    chk("t4_ready_idle", 32'(bus.cfg_ready), 1);
    step(1);
    bus.cfg_valid = 1'b0;
    $display("held cfg accepted -> ok=%b", bus.cfg_ok);
    chk("t4_ok", 32'(bus.cfg_ok), 1);
    pulse_start();
    run_cap(6);
    chk("t4_new_wave", 32'(wave_h[5:0]), 32'd14);
    chk("t4_new_tick1", 32'(tick_h[1][5:0]), 32'd2);
    chk("t4_new_tick0", 32'(tick_h[0][5:0]), 0);
    do_stop();

    // Saturation of the period counter.
    send_cfg(2, 0, 1, 4'b0001);
    pulse_start();
    step(40);
    chk("t4_saturate", 32'(bus.periods), PMAX);
    do_stop();

    // Asynchronous reset between edges while running.
    pulse_start();
    step(3);
    chk("t5_busy_before", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset -> busy=%b wave=%b ok=%b", bus.busy, bus.wave_out, bus.cfg_ok);
    chk("t5_wave", 32'(bus.wave_out), 0);
    chk("t5_tick", 32'(bus.tick), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_cfg_ok", 32'(bus.cfg_ok), 0);
    chk("t5_periods", 32'(bus.periods), 0);
    step(1);
    rst_n = 1'b1;
    pulse_start();
    step(1);
    chk("t5_start_ignored", 32'(bus.busy), 0);
    chk("t5_wave_after", 32'(bus.wave_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/waveform_sched.md
Name: waveform_sched

Overview:
- Programmable waveform scheduler for clock-constraint test designs.
- Validates a (period, rise, fall) waveform configuration, then produces a periodic registered waveform and per-consumer single-cycle enable ticks.
- Downstream counter instances use the ticks as clock enables.
- Sits between a config source and N_OUT counter consumers. Invalid waveforms are rejected with a sticky error, never run.

Parameters:
CNT_W, 8, width of period/rise/fall and phase counter
N_OUT, 4, number of tick consumers
PCNT_W, 16, width of completed-period counter

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept possible (IDLE or ERR)
cfg_period  in  CNT_W  waveform period in clk cycles
cfg_rise  in  CNT_W  phase of rising edge
cfg_fall  in  CNT_W  phase of falling edge
cfg_mask  in  N_OUT  per-consumer tick enable
start  in  1  begin running the validated waveform
stop  in  1  halt running
wave_out  out  1  generated waveform
tick  out  N_OUT  one-cycle pulse per masked consumer at each rise phase
busy  out  1  state==RUN
cfg_ok  out  1  a valid config is loaded
cfg_err  out  1  last accepted config invalid (sticky until next accept)
periods  out  PCNT_W  completed periods since start, saturating

Behaviour:
- Async reset values:
  - state=IDLE, phase=0
  - wave_out=0, tick=0, busy=0, cfg_ok=0, cfg_err=0, periods=0
  - cfg registers=0
- States:
  - IDLE: cfg_ready=1.
  - RUN: cfg_ready=0.
  - ERR: cfg_ready=1.
- Config accept: cfg_valid&&cfg_ready at an edge.
  - Latch period/rise/fall/mask.
  - Valid iff period>=2 && rise<fall && fall<period.
  - Valid: cfg_ok=1, cfg_err=0, next state IDLE.
  - Invalid: cfg_ok=0, cfg_err=1, next state ERR.
  - Config offered during RUN is not accepted; the source holds it.
- IDLE->RUN: start && cfg_ok && !stop. Sets phase=0 and periods=0. start is ignored in IDLE without cfg_ok, and ignored in ERR.
- RUN, each edge:
  - phase <= (phase==period-1) ? 0 : phase+1.
  - On wrap, periods increments, saturating at all-ones.
- Output timing: outputs are registered from the current phase, so they lag phase by exactly 1 cycle.
  - wave_out <= (phase>=rise && phase<fall).
  - tick[i] <= mask[i] && (phase==rise).
- RUN->IDLE on stop at the next edge.
  - wave_out=0, tick=0, phase=0; periods holds.
  - stop wins over start when both are high in the same cycle.
- Duty width: wave_out high for exactly fall-rise cycles per period. Period length is exactly `period` cycles.
- Reset mid-RUN: all outputs return to reset values immediately (async). Configuration is lost and cfg_ok=0.
- Width rule: all phase compares are unsigned CNT_W. The period==2^CNT_W case is unreachable by construction.

Decomposition:
- Shared package waveform_pkg holds:
  - state enum {IDLE, RUN, ERR}
  - waveform config struct {period, rise, fall}
  - function wave_cfg_valid()
- One natural sub-module: waveform_phase_cnt.
  - Contains the phase counter, wrap detect, and saturating periods counter.
  - Interface: enable, clear, period in; phase, wrap, periods out.
- FSM, output registers and config handshake stay in the top.

Test Plan:
1. Reset, then config period=5 rise=1 fall=3 mask=4'b0101, then start.
   - Required: cfg_ok=1 and cfg_ready=0 once in RUN.
   - wave_out pattern per 5-cycle window is 0,1,1,0,0, starting 1 cycle after start edge+1.
   - tick[0] and tick[2] pulse once per period, aligned with wave_out rising; tick[1] and tick[3] stay 0.
2. Invalid configs, one per attempt:
   - period=1 rise=0 fall=0 -> cfg_err=1, state ERR, start ignored, wave_out stays 0.
   - rise=3 fall=3 period=8 -> cfg_err=1.
   - fall=8 period=8 -> cfg_err=1.
   - Then valid period=4 rise=0 fall=2 -> cfg_err=0, cfg_ok=1.
3. Run period=4 rise=0 fall=2 for 10 cycles, then assert start and stop together.
   - Required: stop wins; next edge busy=0, wave_out=0, tick=0.
   - periods=2 and holds.
4. Handshake and saturation:
   - Hold cfg_valid with a new config during RUN -> cfg_ready=0 and config unchanged. After stop, accepted on first IDLE edge.
   - With PCNT_W=4, period=2, run 40 cycles -> periods saturates at 15.
5. Assert rst_n=0 mid-RUN between edges.
   - Required: wave_out, tick, busy, cfg_ok drop to 0 immediately.
   - After release, start without a new config is ignored.
